// File: rtl/keycode_answer_pkg.sv
// Shared types, HID usage constants and key decode for the keycode answer-entry block.
package keycode_answer_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_F     = 8'h09;
    localparam logic [7:0] HID_1     = 8'h1E;
    localparam logic [7:0] HID_9     = 8'h26;
    localparam logic [7:0] HID_0     = 8'h27;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_BKSP  = 8'h2A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK
    } state_e;

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_DIGIT,
        KEY_BKSP,
        KEY_ENTER
    } key_class_e;

    typedef struct packed {
        key_class_e cls;
        logic [3:0] value;
    } key_t;

    function automatic key_t decode_key(input logic [7:0] code);
        key_t k;
        k.cls   = KEY_NONE;
        k.value = 4'h0;
        if (code >= HID_A && code <= HID_F) begin
            k.cls   = KEY_DIGIT;
            k.value = 4'(code - HID_A) + 4'hA;
        end else if (code >= HID_1 && code <= HID_9) begin
            k.cls   = KEY_DIGIT;
            k.value = 4'(code - HID_1) + 4'h1;
        end else if (code == HID_0) begin
            k.cls   = KEY_DIGIT;
        end else if (code == HID_BKSP) begin
            k.cls   = KEY_BKSP;
        end else if (code == HID_ENTER) begin
            k.cls   = KEY_ENTER;
        end
        return k;
    endfunction

endpackage

// File: rtl/keycode_answer_entry_detect.sv
// Turns the raw HID keycode stream into one-cycle press events with a decoded class and value.
module hid_keypress_detect
    import keycode_answer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    output logic       key_event,
    output key_class_e key_class,
    output logic [3:0] key_value
);

    logic [7:0] keycode_prev;
    key_t       decoded;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            keycode_prev <= 8'h00;
        end else begin
            keycode_prev <= keycode;
        end
    end

    // A held key repeats the same code, so only a change to a non-zero code counts.
    assign key_event = (keycode != 8'h00) && (keycode != keycode_prev);
    assign decoded   = decode_key(keycode);
    assign key_class = decoded.cls;
    assign key_value = decoded.value;

endmodule

// File: rtl/keycode_answer_entry.sv
// Four-digit hex answer entry from HID keycodes with compare and optional answer window.
// Define KEYCODE_ANSWER_TIMEOUT_EN to enable the TIMEOUT_CYCLES answer-window timer.
module keycode_answer_entry
    import keycode_answer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [7:0]  keycode,
    input  logic [15:0] target,
    input  logic        start,
    output logic [15:0] entry_digits,
    output logic [2:0]  digit_count,
    output logic        busy,
    output logic        result_valid,
    output logic        result_correct,
    output logic        result_timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("keycode_answer_entry: TIMEOUT_CYCLES must be at least 2");
    end

    state_e      state, state_next;
    logic        key_event;
    key_class_e  key_class;
    logic [3:0]  key_value;
    logic [15:0] target_q;
    logic        timer_zero;
    logic        do_start, do_timeout, do_enter, do_digit, do_bksp;

    hid_keypress_detect u_detect (
        .clk       (clk_clk),
        .reset_n   (reset_reset_n),
        .keycode   (keycode),
        .key_event (key_event),
        .key_class (key_class),
        .key_value (key_value)
    );

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority inside ENTRY: start, then timeout, then the key event.
    always_comb begin
        logic in_entry_keys;
        do_start      = start && (state != ST_CHECK);
        do_timeout    = (state == ST_ENTRY) && !start && timer_zero;
        in_entry_keys = (state == ST_ENTRY) && !start && !timer_zero && key_event;
        do_enter      = in_entry_keys && (key_class == KEY_ENTER)
                        && (digit_count == 3'(NUM_DIGITS));
        do_digit      = in_entry_keys && (key_class == KEY_DIGIT)
                        && (digit_count < 3'(NUM_DIGITS));
        do_bksp       = in_entry_keys && (key_class == KEY_BKSP)
                        && (digit_count != 3'd0);

        state_next = state;
        case (state)
            ST_IDLE:  if (do_start) state_next = ST_ENTRY;
            ST_ENTRY: begin
                if (do_start)        state_next = ST_ENTRY;
                else if (do_timeout) state_next = ST_IDLE;
                else if (do_enter)   state_next = ST_CHECK;
            end
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_ENTRY) || (state == ST_CHECK);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            entry_digits   <= 16'h0000;
            digit_count    <= 3'd0;
            result_valid   <= 1'b0;
            result_correct <= 1'b0;
            target_q       <= 16'h0000;
        end else begin
            result_valid <= 1'b0;
            if (do_start) begin
                entry_digits   <= 16'h0000;
                digit_count    <= 3'd0;
                result_correct <= 1'b0;
                target_q       <= target;
            end else if (do_timeout) begin
                result_valid   <= 1'b1;
                result_correct <= 1'b0;
            end else if (do_enter) begin
                result_valid   <= 1'b1;
                result_correct <= (entry_digits == target_q);
            end else if (do_digit) begin
                entry_digits <= {entry_digits[11:0], key_value};
                digit_count  <= digit_count + 3'd1;
            end else if (do_bksp) begin
                entry_digits <= entry_digits >> 4;
                digit_count  <= digit_count - 3'd1;
            end
        end
    end

`ifdef KEYCODE_ANSWER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0] timer;

    assign timer_zero = (timer == '0);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            timer          <= '0;
            result_timeout <= 1'b0;
        end else if (do_start) begin
            timer          <= TIMER_W'(TIMEOUT_CYCLES - 1);
            result_timeout <= 1'b0;
        end else if (do_timeout) begin
            result_timeout <= 1'b1;
        end else if (state == ST_ENTRY) begin
            timer <= timer - 1'b1;
        end
    end
`else
    assign timer_zero     = 1'b0;
    assign result_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_keycode_answer_entry.sv
// Directed and randomized bench for keycode_answer_entry against a queue-based answer model.
module tb_keycode_answer_entry;

    localparam int unsigned TIMEOUT = 16;
`ifdef KEYCODE_ANSWER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [7:0]  keycode;
    logic [15:0] target;
    logic        start;
    logic [15:0] entry_digits;
    logic [2:0]  digit_count;
    logic        busy;
    logic        result_valid;
    logic        result_correct;
    logic        result_timeout;

    keycode_answer_entry #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .keycode        (keycode),
        .target         (target),
        .start          (start),
        .entry_digits   (entry_digits),
        .digit_count    (digit_count),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_correct (result_correct),
        .result_timeout (result_timeout)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    // Reference model: phase 0 idle, 1 answering, 2 one-cycle check.
    int          m_phase;
    logic [3:0]  m_q[$];
    logic [15:0] m_tgt;
    logic [7:0]  m_prev;
    int          m_elapsed;
    logic        m_valid, m_correct, m_timeout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // -1 ignored, 0..15 digit, 16 backspace, 17 enter
    function automatic int classify(input logic [7:0] k);
        if (k >= 8'h04 && k <= 8'h09) return 10 + int'(k) - 4;
        if (k >= 8'h1E && k <= 8'h26) return 1 + int'(k) - 30;
        if (k == 8'h27) return 0;
        if (k == 8'h2A) return 16;
        if (k == 8'h28) return 17;
        return -1;
    endfunction

    function automatic logic [7:0] code_of(input logic [3:0] d);
        if (d == 4'h0) return 8'h27;
        if (d >= 4'hA) return 8'h04 + 8'(d - 4'hA);
        return 8'h1D + 8'(d);
    endfunction

    function automatic logic [15:0] digits_value();
        logic [15:0] v = 16'h0;
        foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
        return v;
    endfunction

    task automatic model_edge();
        int c;
        logic press;
        if (!reset_reset_n) begin
            m_prev = 8'h0; m_phase = 0; m_q.delete(); m_tgt = 16'h0;
            m_valid = 1'b0; m_correct = 1'b0; m_timeout = 1'b0; m_elapsed = 0;
            return;
        end
        press  = (keycode != 8'h0) && (keycode != m_prev);
        m_prev = keycode;
        c = press ? classify(keycode) : -1;
        m_valid = 1'b0;
        if (m_phase == 2) begin
            m_phase = 0;
        end else if (start) begin
            m_phase = 1; m_q.delete(); m_correct = 1'b0; m_timeout = 1'b0;
            m_tgt = target; m_elapsed = 0;
        end else if (m_phase == 1) begin
            if (TO_EN && m_elapsed == int'(TIMEOUT) - 1) begin
                m_phase = 0; m_valid = 1'b1; m_timeout = 1'b1; m_correct = 1'b0;
            end else begin
                m_elapsed++;
                if (c == 17 && m_q.size() == 4) begin
                    m_phase = 2; m_valid = 1'b1; m_correct = (digits_value() == m_tgt);
                end else if (c >= 0 && c < 16 && m_q.size() < 4) begin
                    m_q.push_back(c[3:0]);
                end else if (c == 16 && m_q.size() > 0) begin
                    void'(m_q.pop_back());
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        model_edge();
        #1;
        if (result_valid === 1'b1) vcount++;
        chk("entry_digits", entry_digits, digits_value());
        chk("digit_count", digit_count, m_q.size());
        chk("busy", busy, m_phase != 0);
        chk("result_valid", result_valid, m_valid);
        chk("result_correct", result_correct, m_correct);
        chk("result_timeout", result_timeout, m_timeout);
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        step();
        keycode = 8'h00;
        step();
    endtask

    task automatic pulse_start(input logic [15:0] t);
        target = t;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    initial begin
        int v0, n;
        logic [7:0] seq035[6];
        reset_reset_n = 1'b0; keycode = 8'h0; target = 16'h0; start = 1'b0;
        step(); step();
        chk("rst_digits", entry_digits, 16'h0);
        chk("rst_busy", busy, 1'b0);
        reset_reset_n = 1'b1;
        step();

        // basic correct answer
        pulse_start(16'h3A7F);
        chk("start_busy", busy, 1'b1);
        press(8'h20); press(8'h04); press(8'h24); press(8'h09);
        chk("b_digits", entry_digits, 16'h3A7F);
        v0 = vcount;
        press(8'h28);
        chk("b_pulses", vcount - v0, 1);
        chk("b_correct", result_correct, 1'b1);
        step();
        chk("b_held_correct", result_correct, 1'b1);

        // wrong digit, fifth digit ignored, backspace fixes
        pulse_start(16'h1234);
        chk("w_cleared", result_correct, 1'b0);
        seq035 = '{8'h1E, 8'h1F, 8'h20, 8'h22, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) press(seq035[i]);
        chk("w_1235", entry_digits, 16'h1235);
        press(8'h21);
        chk("w_fifth", entry_digits, 16'h1235);
        press(8'h2A);
        chk("w_bksp", entry_digits, 16'h0123);
        chk("w_bksp_cnt", digit_count, 3'd3);
        press(8'h21);
        chk("w_1234", entry_digits, 16'h1234);
        v0 = vcount;
        press(8'h28);
        chk("w_pulses", vcount - v0, 1);
        chk("w_correct", result_correct, 1'b1);

        // held key then early enter
        pulse_start(16'hBEEF);
        keycode = 8'h1E;
        for (int i = 0; i < 100; i++) step();
        chk("h_count", digit_count, 3'd1);
        keycode = 8'h00; step();
        v0 = vcount;
        press(8'h28);
        chk("h_busy", busy, 1'b1);
        chk("h_no_pulse", vcount - v0, 0);

        // answer window
        pulse_start(16'h0000);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (result_valid === 1'b1 && n == 0) n = i;
        end
        if (TO_EN) begin
            chk("t_latency", n, 16);
            chk("t_flag", result_timeout, 1'b1);
            chk("t_idle", busy, 1'b0);
        end else begin
            chk("t_none", n, 0);
            chk("t_still_busy", busy, 1'b1);
        end

        // start beats a coincident digit; reset aborts the window
        pulse_start(16'h5555);
        press(8'h22); press(8'h22 + 8'h01);
        target = 16'h9999; start = 1'b1; keycode = 8'h27;
        step();
        start = 1'b0; keycode = 8'h00;
        chk("s_count", digit_count, 3'd0);
        press(8'h26);
        v0 = vcount;
        reset_reset_n = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("r_busy", busy, 1'b0);
        chk("r_digits", entry_digits, 16'h0);
        chk("r_count", digit_count, 3'd0);
        chk("r_no_pulse", vcount - v0, 0);
        reset_reset_n = 1'b1;
        step();

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r = int'($urandom_range(0, 99));
            start = ($urandom_range(0, 59) == 0);
            if (start) target = ($urandom_range(0, 3) == 0) ? 16'h1234 : 16'($urandom());
            reset_reset_n = ($urandom_range(0, 499) != 0);
            if (r < 30) begin
                keycode = keycode;
            end else if (r < 50) begin
                keycode = 8'h00;
            end else if (r < 75) begin
                keycode = (m_q.size() < 4) ? code_of(m_tgt[4*(3 - m_q.size()) +: 4])
                                           : 8'h28;
            end else if (r < 82) begin
                keycode = 8'h2A;
            end else if (r < 88) begin
                keycode = 8'h28;
            end else begin
                keycode = 8'($urandom());
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keycode_answer_entry.md
KEYCODE_ANSWER_ENTRY -- requirements
Module: keycode_answer_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500000000, answer window length in clk_clk cycles (10 s at 50 MHz); SHALL be at least 2.
REQ-002 clk_clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-003 reset_reset_n  input  1  reset, synchronous and active-low.
REQ-004 keycode  input  8  USB HID usage code from the SoC keycode PIO; 0x00 means no key; synchronous to clk_clk.
REQ-005 target  input  16  four-digit hex answer written by software; SHALL be sampled only on an accepted start.
REQ-006 start  input  1  one-cycle pulse that opens a new answer window.
REQ-007 entry_digits  output  16  digits entered so far, right-justified nibbles; feeds the hex display.
REQ-008 digit_count  output  3  number of digits entered, 0..4.
REQ-009 busy  output  1  high while in ENTRY or CHECK.
REQ-010 result_valid  output  1  one-cycle pulse when a result is produced.
REQ-011 result_correct  output  1  held result: the entry matched target.
REQ-012 result_timeout  output  1  held result: the window expired.

Function
REQ-013 Press event: keycode != 0 and keycode != the previous cycle's registered keycode; held or repeated codes SHALL NOT generate further events.
REQ-014 Decode:
  - 0x04..0x09 -> 0xA..0xF
  - 0x1E..0x26 -> 0x1..0x9
  - 0x27 -> 0x0
  - 0x2A -> BACKSPACE
  - 0x28 -> ENTER
  - all other codes SHALL be ignored.
REQ-015 The state machine SHALL have three states: IDLE, ENTRY and CHECK.
REQ-016 IDLE + start -> ENTRY:
  - clear entry_digits and digit_count;
  - clear result_correct and result_timeout;
  - latch target;
  - load the timer with TIMEOUT_CYCLES-1.
REQ-017 ENTRY, digit event with digit_count<4: entry_digits <= {entry_digits[11:0], digit}, digit_count +1, effective the next cycle.
REQ-018 ENTRY, digit event with digit_count==4: the event SHALL be ignored.
REQ-019 ENTRY, BACKSPACE with digit_count>0: entry_digits <= entry_digits>>4, digit_count -1; with digit_count==0 it SHALL be ignored.
REQ-020 ENTRY, ENTER with digit_count==4 SHALL go to CHECK; with fewer digits it SHALL be ignored.
REQ-021 CHECK SHALL last exactly one cycle and then return to IDLE with:
  - result_valid=1 for that cycle;
  - result_correct = (entry_digits == latched target);
  - result_timeout=0.
REQ-022 start while in ENTRY SHALL restart the window exactly as REQ-016; start while in CHECK SHALL be ignored.
REQ-023 start and a press event in the same cycle: start SHALL win and the key event SHALL be discarded.
REQ-024 Key events in IDLE SHALL be ignored.
REQ-025 entry_digits SHALL hold its value in IDLE so the display keeps the last answer.
REQ-026 Result flags SHALL hold until the next accepted start.

Reset
REQ-027 With reset_reset_n=0 at a clock edge, the block SHALL enter IDLE and all outputs, the previous-keycode register, the latched target and the timer SHALL be 0.
REQ-028 Reset mid-ENTRY SHALL abort the window without a result_valid pulse.
REQ-029 reset_reset_n SHALL take priority over start.

Configuration
REQ-030 Macro KEYCODE_ANSWER_TIMEOUT_EN, defined:
  - the timer decrements once per cycle in ENTRY;
  - when it reads 0 in ENTRY, the block SHALL go to IDLE with result_valid=1, result_timeout=1, result_correct=0;
  - ENTER in that same cycle SHALL be ignored (timeout wins).
REQ-031 Macro KEYCODE_ANSWER_TIMEOUT_EN, undefined:
  - no timer logic;
  - result_timeout SHALL be tied to 0;
  - ENTRY lasts until ENTER, start or reset.

Structure
REQ-032 Package keycode_answer_pkg SHALL hold:
  - the state enum;
  - the HID constants (0x04, 0x09, 0x1E, 0x26, 0x27, 0x28, 0x2A);
  - the digit/BACKSPACE/ENTER/NONE decode function;
  - NUM_DIGITS=4.
REQ-033 Sub-module hid_keypress_detect SHALL contain the previous-keycode register, the REQ-013 edge logic and the decode, and SHALL output a one-cycle event plus its decoded class and value.

Verification
REQ-034 Basic correct answer: target=0x3A7F, start, keys 0x20,0x04,0x24,0x09 (each separated by 0x00), then 0x28 -> entry_digits=0x3A7F, one result_valid, result_correct=1.
REQ-035 Wrong answer with backspace: target=0x1234, keys 1,2,3,5, BACKSPACE, 4, ENTER -> the backspace takes entry_digits 0x1235 -> 0x0123 with digit_count 4->3; final entry 0x1234, correct=1; a fifth digit before ENTER SHALL leave entry unchanged.
REQ-036 Held key and early ENTER: keycode 0x1E held 100 cycles -> digit_count=1 only; ENTER at count 1 -> still busy, no result_valid.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=16): start, no keys -> result_valid exactly 16 cycles after start, result_timeout=1, result_correct=0.
REQ-038 Start priority and reset: start coincident with digit 0x27 mid-entry -> digit_count=0 next cycle; reset_reset_n low mid-ENTRY -> IDLE, all outputs 0, no result_valid.
